sdr_tune_ctrl: RTL and testbench



---
 rtl/sdr_tune_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_sdr_tune_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_tune_ctrl.sv
// UART command decoder and tuning register file for the 1-bit SDR receiver:
// per-channel NCO phase increments, shared CIC gain, and a K/E acknowledge byte.
module sdr_tune_ctrl #(
   parameter int unsigned      WIDTH       = 64,
   parameter int unsigned      NUM_CH      = 2,
   parameter int unsigned      GAIN_W      = 8,
   parameter int unsigned      GAIN_MAX    = 3,
   parameter logic [WIDTH-1:0] INC_MAX     = {1'b0, {(WIDTH-1){1'b1}}},
   parameter logic [WIDTH-1:0] PRESET0     = 64'h4CF41F212D77318,
   parameter logic [WIDTH-1:0] PRESET1     = 64'h1aa60f8b8911654,
   parameter logic [WIDTH-1:0] PRESET2     = 64'h1dc38c076704516d,
   parameter logic [WIDTH-1:0] PRESET3     = 64'h1d60d923295482c6,
   parameter logic [WIDTH-1:0] STEP_FINE   = 64'h1436a8cdf6f3,
   parameter logic [WIDTH-1:0] STEP_MID    = 64'hca22980ba57e,
   parameter logic [WIDTH-1:0] STEP_COARSE = 64'h71b375868d170,
   parameter bit               ECHO        = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rx_dv,
   input  logic [7:0]              rx_byte,
   input  logic                    tx_busy,
   output logic                    tx_dv,
   output logic [7:0]              tx_byte,
   output logic [NUM_CH*WIDTH-1:0] phase_inc,
   output logic [NUM_CH-1:0]       inc_upd,
   output logic [GAIN_W-1:0]       gain,
   output logic                    gain_upd,
   output logic [2:0]              active_ch
);

   localparam logic [7:0] CMD_D0    = 8'h30;  // '0'
   localparam logic [7:0] CMD_D9    = 8'h39;  // '9'
   localparam logic [7:0] CMD_CH0   = 8'h41;  // 'A'
   localparam logic [7:0] CMD_PRE0  = 8'h61;  // 'a'
   localparam logic [7:0] CMD_PRE1  = 8'h62;  // 'b'
   localparam logic [7:0] CMD_PRE2  = 8'h66;  // 'f'
   localparam logic [7:0] CMD_PRE3  = 8'h67;  // 'g'
   localparam logic [7:0] CMD_ADD_C = 8'h6d;  // 'm'
   localparam logic [7:0] CMD_SUB_C = 8'h6e;  // 'n'
   localparam logic [7:0] CMD_SUB_F = 8'h6f;  // 'o'
   localparam logic [7:0] CMD_ADD_F = 8'h70;  // 'p'
   localparam logic [7:0] CMD_SUB_M = 8'h71;  // 'q'
   localparam logic [7:0] CMD_ADD_M = 8'h72;  // 'r'
   localparam logic [7:0] ACK_OK    = 8'h4B;  // 'K'
   localparam logic [7:0] ACK_ERR   = 8'h45;  // 'E'

   typedef enum logic {ST_IDLE, ST_PEND} ack_state_t;

   logic                    dv_q, dv_d;
   logic [7:0]              byte_q, byte_d;
   logic [WIDTH-1:0]        inc_q [NUM_CH];
   logic [WIDTH-1:0]        inc_d [NUM_CH];
   logic [NUM_CH-1:0]       inc_upd_q, inc_upd_d;
   logic [GAIN_W-1:0]       gain_q, gain_d;
   logic                    gain_upd_q, gain_upd_d;
   logic [2:0]              active_ch_q, active_ch_d;
   ack_state_t              state_q, state_d;
   logic [7:0]              code_q, code_d;
   logic                    tx_dv_q, tx_dv_d;
   logic [7:0]              tx_byte_q, tx_byte_d;

   logic                    tune, set_gain, set_ch, accept;
   logic [WIDTH-1:0]        cur_inc, new_inc;
   logic [7:0]              digit, sel_k;

   // Tuning arithmetic saturates instead of wrapping: [0, INC_MAX].
   function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, INC_MAX}) ? INC_MAX : s[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} - {1'b0, b};
      return s[WIDTH] ? '0 : s[WIDTH-1:0];
   endfunction

   assign dv_d   = rx_dv;
   assign byte_d = rx_byte;
   assign digit  = byte_q - CMD_D0;
   assign sel_k  = byte_q - CMD_CH0;

   always_comb begin
      cur_inc = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (active_ch_q == 3'(k)) cur_inc = inc_q[k];
      end
   end

   always_comb begin
      tune     = 1'b1;
      set_gain = 1'b0;
      set_ch   = 1'b0;
      new_inc  = cur_inc;
      case (byte_q)
         CMD_PRE0:  new_inc = PRESET0;
         CMD_PRE1:  new_inc = PRESET1;
         CMD_PRE2:  new_inc = PRESET2;
         CMD_PRE3:  new_inc = PRESET3;
         CMD_SUB_C: new_inc = sat_sub(cur_inc, STEP_COARSE);
         CMD_ADD_C: new_inc = sat_add(cur_inc, STEP_COARSE);
         CMD_SUB_M: new_inc = sat_sub(cur_inc, STEP_MID);
         CMD_ADD_M: new_inc = sat_add(cur_inc, STEP_MID);
         CMD_SUB_F: new_inc = sat_sub(cur_inc, STEP_FINE);
         CMD_ADD_F: new_inc = sat_add(cur_inc, STEP_FINE);
         default: begin
            tune = 1'b0;
            if (byte_q >= CMD_D0 && byte_q <= CMD_D9) begin
               set_gain = ({24'd0, digit} <= GAIN_MAX);
            end else if (byte_q >= CMD_CH0) begin
               set_ch = ({24'd0, sel_k} < NUM_CH);
            end
         end
      endcase
      accept = tune | set_gain | set_ch;
   end

   always_comb begin
      inc_d       = inc_q;
      inc_upd_d   = '0;
      gain_d      = gain_q;
      gain_upd_d  = 1'b0;
      active_ch_d = active_ch_q;
      if (dv_q) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (tune && active_ch_q == 3'(k)) begin
               inc_d[k]     = new_inc;
               inc_upd_d[k] = 1'b1;
            end
         end
         if (set_gain) begin
            gain_d     = GAIN_W'(digit);
            gain_upd_d = 1'b1;
         end
         if (set_ch) active_ch_d = sel_k[2:0];
      end
   end

   // A newly decoded command takes priority over sending, so a burst collapses
   // into a single acknowledge carrying the code of its last command.
   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;
      if (ECHO) begin
         if (dv_q) begin
            code_d  = accept ? ACK_OK : ACK_ERR;
            state_d = ST_PEND;
         end else if (state_q == ST_PEND && !tx_busy) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = code_q;
            state_d   = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_q        <= 1'b0;
         byte_q      <= '0;
         for (int k = 0; k < NUM_CH; k++) inc_q[k] <= PRESET0;
         inc_upd_q   <= '0;
         gain_q      <= '0;
         gain_upd_q  <= 1'b0;
         active_ch_q <= '0;
         state_q     <= ST_IDLE;
         code_q      <= '0;
         tx_dv_q     <= 1'b0;
         tx_byte_q   <= '0;
      end else begin
         dv_q        <= dv_d;
         byte_q      <= byte_d;
         for (int k = 0; k < NUM_CH; k++) inc_q[k] <= inc_d[k];
         inc_upd_q   <= inc_upd_d;
         gain_q      <= gain_d;
         gain_upd_q  <= gain_upd_d;
         active_ch_q <= active_ch_d;
         state_q     <= state_d;
         code_q      <= code_d;
         tx_dv_q     <= tx_dv_d;
         tx_byte_q   <= tx_byte_d;
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) phase_inc[k*WIDTH +: WIDTH] = inc_q[k];
   end

   assign inc_upd   = inc_upd_q;
   assign gain      = gain_q;
   assign gain_upd  = gain_upd_q;
   assign active_ch = active_ch_q;
   assign tx_dv     = tx_dv_q;
   assign tx_byte   = tx_byte_q;

endmodule

// File: tb/tb_sdr_tune_ctrl.sv
// Bench for sdr_tune_ctrl: directed command sequences plus random traffic,
// compared every cycle against a command-level model of the tuning registers.
module tb_sdr_tune_ctrl;

   localparam int          NCH  = 2;
   localparam logic [63:0] P0   = 64'h4CF41F212D77318;
   localparam logic [63:0] P1   = 64'h1aa60f8b8911654;
   localparam logic [63:0] P2   = 64'h1dc38c076704516d;
   localparam logic [63:0] P3   = 64'h1d60d923295482c6;
   localparam logic [63:0] SF   = 64'h1436a8cdf6f3;
   localparam logic [63:0] SM   = 64'hca22980ba57e;
   localparam logic [63:0] SC   = 64'h71b375868d170;
   localparam logic [63:0] IMAX = 64'h7fffffffffffffff;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx_dv = 1'b0;
   logic [7:0]        rx_byte = 8'h00;
   logic              tx_busy = 1'b0;
   logic              tx_dv;
   logic [7:0]        tx_byte;
   logic [NCH*64-1:0] phase_inc;
   logic [NCH-1:0]    inc_upd;
   logic [7:0]        gain;
   logic              gain_upd;
   logic [2:0]        active_ch;

   always #5 clk = ~clk;

   sdr_tune_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_dv     (rx_dv),
      .rx_byte   (rx_byte),
      .tx_busy   (tx_busy),
      .tx_dv     (tx_dv),
      .tx_byte   (tx_byte),
      .phase_inc (phase_inc),
      .inc_upd   (inc_upd),
      .gain      (gain),
      .gain_upd  (gain_upd),
      .active_ch (active_ch)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Command-level model: register contents plus the byte waiting to be decoded.
   logic [63:0]    m_inc [NCH];
   logic [7:0]     m_gain;
   int             m_ch;
   bit             m_pend;
   logic [7:0]     m_code;
   logic           m_prev_dv;
   logic [7:0]     m_prev_byte;
   logic [NCH-1:0] e_inc_upd;
   logic           e_gain_upd;
   logic           e_tx_dv;
   logic [7:0]     e_tx_byte;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) m_inc[k] = P0;
      m_gain = 8'd0; m_ch = 0; m_pend = 1'b0; m_code = 8'h00;
      m_prev_dv = 1'b0; m_prev_byte = 8'h00;
      e_inc_upd = '0; e_gain_upd = 1'b0; e_tx_dv = 1'b0; e_tx_byte = 8'h00;
   endtask

   task automatic apply(input logic [7:0] b, output bit acc);
      logic [63:0] cur;
      logic [63:0] nv;
      bit          tune;
      cur  = m_inc[m_ch];
      nv   = cur;
      tune = 1'b1;
      acc  = 1'b0;
      case (b)
         "a": nv = P0;
         "b": nv = P1;
         "f": nv = P2;
         "g": nv = P3;
         "m": nv = (cur + SC > IMAX) ? IMAX : cur + SC;
         "n": nv = (SC > cur) ? 64'd0 : cur - SC;
         "r": nv = (cur + SM > IMAX) ? IMAX : cur + SM;
         "q": nv = (SM > cur) ? 64'd0 : cur - SM;
         "p": nv = (cur + SF > IMAX) ? IMAX : cur + SF;
         "o": nv = (SF > cur) ? 64'd0 : cur - SF;
         default: tune = 1'b0;
      endcase
      if (tune) begin
         m_inc[m_ch] = nv;
         e_inc_upd[m_ch] = 1'b1;
         acc = 1'b1;
      end else if (b >= "0" && b <= "9") begin
         if (int'(b) - 48 <= 3) begin
            m_gain = b - 8'd48;
            e_gain_upd = 1'b1;
            acc = 1'b1;
         end
      end else if (int'(b) - 65 >= 0 && int'(b) - 65 < NCH) begin
         m_ch = int'(b) - 65;
         acc = 1'b1;
      end
   endtask

   // Called just after a rising edge, using the inputs that were stable at it.
   task automatic model_edge();
      bit acc;
      e_inc_upd = '0; e_gain_upd = 1'b0; e_tx_dv = 1'b0;
      if (m_pend && !tx_busy && !m_prev_dv) begin
         e_tx_dv = 1'b1; e_tx_byte = m_code; m_pend = 1'b0;
      end
      if (m_prev_dv) begin
         apply(m_prev_byte, acc);
         m_code = acc ? 8'h4B : 8'h45;
         m_pend = 1'b1;
      end
      m_prev_dv = rx_dv; m_prev_byte = rx_byte;
   endtask

   task automatic check_all();
      logic [NCH*64-1:0] exp_pi;
      for (int k = 0; k < NCH; k++) exp_pi[k*64 +: 64] = m_inc[k];
      check("phase_inc", phase_inc, exp_pi);
      check("inc_upd", inc_upd, e_inc_upd);
      check("gain", gain, m_gain);
      check("gain_upd", gain_upd, e_gain_upd);
      check("active_ch", active_ch, 3'(m_ch));
      check("tx_dv", tx_dv, e_tx_dv);
      check("tx_byte", tx_byte, e_tx_byte);
   endtask

   task automatic tick(input logic dv, input logic [7:0] b, input logic busy);
      rx_dv = dv; rx_byte = b; tx_busy = busy;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n, input logic busy);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00, busy);
   endtask

   initial begin
      string cmds;
      int    n_tx;
      logic [7:0] b;
      cmds = "0123456789abfgmnopqrABCDEKZxy";
      model_reset();
      #12;
      check_all();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // single step up on channel 0, acknowledge with busy low
      tick(1'b1, "r", 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      check("r_inc", phase_inc[63:0], P0 + SM);
      check("r_upd", inc_upd, 2'b01);
      tick(1'b0, 8'h00, 1'b0);
      check("r_txdv", tx_dv, 1'b1);
      check("r_txbyte", tx_byte, 8'h4B);
      idle(2, 1'b0);

      // channel select immediately followed by a preset load
      tick(1'b1, "B", 1'b0);
      tick(1'b1, "b", 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      check("sel_ch", active_ch, 3'd1);
      check("sel_inc1", phase_inc[127:64], P1);
      check("sel_upd", inc_upd, 2'b10);
      idle(3, 1'b0);

      // burst with transmitter busy: one acknowledge after release
      tick(1'b1, "A", 1'b0);
      tick(1'b1, "a", 1'b0);
      idle(3, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b1, "m", 1'b1);
      idle(4, 1'b1);
      check("burst_inc", phase_inc[63:0], P0 + 3 * SC);
      n_tx = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 8'h00, 1'b0);
         if (tx_dv) begin
            n_tx++;
            check("burst_code", tx_byte, 8'h4B);
         end
      end
      check("burst_ntx", n_tx, 1);

      // gain accept then reject, illegal channel
      tick(1'b1, "2", 1'b0);
      tick(1'b1, "7", 1'b0);
      idle(4, 1'b0);
      check("gain_keep", gain, 8'd2);
      tick(1'b1, "C", 1'b0);
      idle(2, 1'b0);
      check("c_reject", tx_byte, 8'h45);
      idle(2, 1'b0);

      // clamp at zero
      tick(1'b1, "a", 1'b0);
      for (int i = 0; i < 200; i++) tick(1'b1, "n", 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b1, "o", 1'b0);
      idle(3, 1'b0);
      check("clamp_zero", phase_inc[63:0], 64'd0);

      // clamp at INC_MAX
      tick(1'b1, "g", 1'b0);
      for (int i = 0; i < 4000; i++) tick(1'b1, "m", 1'(i % 3 == 0));
      idle(3, 1'b0);
      check("clamp_max", phase_inc[63:0], IMAX);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
         else b = cmds[$urandom_range(0, cmds.len() - 1)];
         tick(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 3) == 0));
      end
      idle(4, 1'b0);

      // reset mid-pipeline drops the queued byte and the pending acknowledge
      tick(1'b1, "r", 1'b1);
      tick(1'b1, "a", 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      idle(2, 1'b0);
      rst_n = 1'b1;
      n_tx = 0;
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 8'h00, 1'b0);
         if (tx_dv) n_tx++;
      end
      check("rst_no_tx", n_tx, 0);
      check("rst_inc0", phase_inc[63:0], P0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
